fetch_pc_unit: RTL and testbench

Fetch-stage PC generator and F/D pipeline register; the consumer of the `PC_sel`/`ret_pc` redirect pair that the decode/execute jump-detect logic drives. It holds the fetch PC and issues instruction-memory requests over a valid/ready handshake. It absorbs hazard stalls with a one-entry hold buffer, applies jump (decode) and branch (execute) redirects, and raises the flush strobes that squash wrong-path instructions.

---
 rtl/fetch_pc_unit.sv | 185 ++++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator with valid/ready instruction-memory requests, F/D register and hold buffer.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise a sticky trap instead of being aligned.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PC_sel,
  input  logic [31:0] ret_pc,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_f,
  output logic [31:0] pc_d,
  output logic [31:0] insn_d,
  output logic        valid_d,
  output logic        flush_d,
  output logic        flush_x,
  output logic        misalign_trap,
  output logic [31:0] bad_addr
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_REDIR_PEND, S_HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_f_nx, pc_d_nx, insn_d_nx;
  logic        valid_d_nx;
  logic [31:0] redir_pc, redir_pc_nx;
  logic [31:0] hold_pc, hold_pc_nx, hold_insn, hold_insn_nx;
  logic        redirect, take, req_base, trapped;
  logic [31:0] target;

  assign redirect  = (PC_sel == 2'b01) || (PC_sel == 2'b10);
  assign flush_d   = redirect;
  assign flush_x   = (PC_sel == 2'b10);
  assign imem_addr = pc_f;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned, trap_q, trap_nx;
  logic [31:0] bad_q, bad_nx;

  assign misaligned    = redirect && (ret_pc[1:0] != 2'b00);
  assign target        = ret_pc;
  assign take          = redirect && !misaligned;
  assign trapped       = trap_q;
  assign misalign_trap = trap_q;
  assign bad_addr      = bad_q;

  // Only the first misaligned target is recorded; the trap blocks fetch until reset.
  always_comb begin
    trap_nx = trap_q;
    bad_nx  = bad_q;
    if (misaligned && !trap_q) begin
      trap_nx = 1'b1;
      bad_nx  = ret_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_q <= 1'b0;
      bad_q  <= 32'h0;
    end else begin
      trap_q <= trap_nx;
      bad_q  <= bad_nx;
    end
  end
`else
  assign target        = ret_pc & 32'hFFFF_FFFC;
  assign take          = redirect;
  assign trapped       = 1'b0;
  assign misalign_trap = 1'b0;
  assign bad_addr      = 32'h0;
`endif

  // An issued request must stay up until the memory completes it.
  always_comb begin
    case (state)
      S_RUN:                req_base = !stall && !redirect;
      S_WAIT, S_REDIR_PEND: req_base = 1'b1;
      default:              req_base = 1'b0;
    endcase
  end

  assign imem_req = req_base && !trapped;

  always_comb begin
    state_nx     = state;
    pc_f_nx      = pc_f;
    pc_d_nx      = pc_d;
    insn_d_nx    = insn_d;
    valid_d_nx   = valid_d;
    redir_pc_nx  = redir_pc;
    hold_pc_nx   = hold_pc;
    hold_insn_nx = hold_insn;

    if (redirect) begin
      insn_d_nx  = NOP_INSN;
      valid_d_nx = 1'b0;
      if (!take) begin
        state_nx = S_RUN;
      end else if ((state == S_WAIT || state == S_REDIR_PEND) && !imem_ready) begin
        redir_pc_nx = target;
        state_nx    = S_REDIR_PEND;
      end else begin
        pc_f_nx  = target;
        state_nx = S_RUN;
      end
    end else begin
      if (!stall) begin
        insn_d_nx  = NOP_INSN;
        valid_d_nx = 1'b0;
      end
      case (state)
        S_RUN: begin
          if (imem_req) begin
            if (imem_ready) begin
              pc_d_nx    = pc_f;
              insn_d_nx  = imem_rdata;
              valid_d_nx = 1'b1;
              pc_f_nx    = pc_f + 32'd4;
            end else begin
              state_nx = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_ready) begin
            pc_f_nx = pc_f + 32'd4;
            if (stall) begin
              hold_pc_nx   = pc_f;
              hold_insn_nx = imem_rdata;
              state_nx     = S_HOLD;
            end else begin
              pc_d_nx    = pc_f;
              insn_d_nx  = imem_rdata;
              valid_d_nx = 1'b1;
              state_nx   = S_RUN;
            end
          end
        end
        S_REDIR_PEND: begin
          if (imem_ready) begin
            pc_f_nx  = redir_pc;
            state_nx = S_RUN;
          end
        end
        default: begin
          if (!stall) begin
            pc_d_nx    = hold_pc;
            insn_d_nx  = hold_insn;
            valid_d_nx = 1'b1;
            state_nx   = S_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RUN;
      pc_f      <= RESET_PC;
      pc_d      <= 32'h0;
      insn_d    <= NOP_INSN;
      valid_d   <= 1'b0;
      redir_pc  <= 32'h0;
      hold_pc   <= 32'h0;
      hold_insn <= 32'h0;
    end else begin
      state     <= state_nx;
      pc_f      <= pc_f_nx;
      pc_d      <= pc_d_nx;
      insn_d    <= insn_d_nx;
      valid_d   <= valid_d_nx;
      redir_pc  <= redir_pc_nx;
      hold_pc   <= hold_pc_nx;
      hold_insn <= hold_insn_nx;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit against a transaction-level reference model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  PC_sel = 2'b00;
  logic [31:0] ret_pc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr, pc_f, pc_d, insn_d, bad_addr;
  logic        valid_d, flush_d, flush_x, misalign_trap;

  int compared = 0;
  int mismatched = 0;

  // Reference model: outstanding request, queued redirect and held word tracked as plain flags.
  logic [31:0] m_pc, m_pcd, m_insn, m_pend_pc, m_held_pc, m_held_insn, m_bad;
  logic        m_valid, m_busy, m_pend, m_held, m_trap;

  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .PC_sel(PC_sel), .ret_pc(ret_pc), .stall(stall),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc_f(pc_f), .pc_d(pc_d), .insn_d(insn_d), .valid_d(valid_d),
    .flush_d(flush_d), .flush_x(flush_x), .misalign_trap(misalign_trap), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc = 32'h0100_0000; m_pcd = 32'h0; m_insn = 32'h0000_0013; m_valid = 1'b0;
    m_busy = 1'b0; m_pend = 1'b0; m_pend_pc = 32'h0; m_held = 1'b0;
    m_held_pc = 32'h0; m_held_insn = 32'h0; m_trap = 1'b0; m_bad = 32'h0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; PC_sel = 2'b00; ret_pc = 32'h0; stall = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    #1;
    checkOutput("rst_pc_f", pc_f, 32'h0100_0000);
    checkOutput("rst_pc_d", pc_d, 32'h0);
    checkOutput("rst_insn_d", insn_d, 32'h0000_0013);
    checkOutput("rst_valid_d", 32'(valid_d), 32'h0);
    checkOutput("rst_trap", 32'(misalign_trap), 32'h0);
    checkOutput("rst_bad_addr", bad_addr, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    modelReset();
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] ret, input logic st,
                               input logic rdy, input logic [31:0] rd);
    logic        redir, exp_req, fired, mis;
    logic [31:0] tgt;
    @(negedge clk);
    PC_sel = sel; ret_pc = ret; stall = st; imem_ready = rdy; imem_rdata = rd;
    #1;
    redir   = (sel == 2'd1) || (sel == 2'd2);
    exp_req = !m_trap && !m_held && (m_busy || (!st && !redir));
`ifdef FETCH_MISALIGN_TRAP_EN
    tgt = ret;
    mis = redir && (ret[1:0] != 2'b00);
`else
    tgt = {ret[31:2], 2'b00};
    mis = 1'b0;
`endif
    checkOutput("imem_req", 32'(imem_req), 32'(exp_req));
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("pc_f", pc_f, m_pc);
    checkOutput("flush_d", 32'(flush_d), 32'(redir));
    checkOutput("flush_x", 32'(flush_x), 32'(sel == 2'd2));
    checkOutput("valid_d", 32'(valid_d), 32'(m_valid));
    checkOutput("insn_d", insn_d, m_insn);
    if (m_valid) checkOutput("pc_d", pc_d, m_pcd);
    checkOutput("misalign_trap", 32'(misalign_trap), 32'(m_trap));
    checkOutput("bad_addr", bad_addr, m_bad);
    @(posedge clk);
    fired = exp_req && rdy;
    if (redir) begin
      m_insn = 32'h0000_0013; m_valid = 1'b0;
      if (mis) begin
        if (!m_trap) m_bad = ret;
        m_trap = 1'b1; m_busy = 1'b0; m_pend = 1'b0; m_held = 1'b0;
      end else if (m_busy && !rdy) begin
        m_pend = 1'b1; m_pend_pc = tgt;
      end else begin
        m_pc = tgt; m_busy = 1'b0; m_pend = 1'b0; m_held = 1'b0;
      end
    end else begin
      if (!st) begin
        m_insn = 32'h0000_0013; m_valid = 1'b0;
      end
      if (m_held) begin
        if (!st) begin
          m_pcd = m_held_pc; m_insn = m_held_insn; m_valid = 1'b1; m_held = 1'b0;
        end
      end else if (fired) begin
        m_busy = 1'b0;
        if (m_pend) begin
          m_pc = m_pend_pc; m_pend = 1'b0;
        end else begin
          if (st) begin
            m_held = 1'b1; m_held_pc = m_pc; m_held_insn = rd;
          end else begin
            m_pcd = m_pc; m_insn = rd; m_valid = 1'b1;
          end
          m_pc = m_pc + 32'd4;
        end
      end else if (exp_req) begin
        m_busy = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] saved_pc, r_ret;
    logic [1:0]  r_sel;
    int          r;
    modelReset();
    doReset();

    // Zero-wait streaming with addr-derived instruction words.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'd0, 32'h0, 1'b0, 1'b1, m_pc ^ 32'hA5A5_0000);
      checkOutput("stream_insn", insn_d, 32'hA4A5_0000 + 32'(4 * k));
      checkOutput("stream_valid", 32'(valid_d), 32'h1);
    end
    checkOutput("stream_pc_f", pc_f, 32'h0100_000C);

    applyStimulus(2'd1, 32'h0100_0040, 1'b0, 1'b1, 32'h1234_5678);
    checkOutput("jump_pc_f", pc_f, 32'h0100_0040);
    checkOutput("jump_bubble", 32'(valid_d), 32'h0);
    applyStimulus(2'd0, 32'h0, 1'b0, 1'b1, 32'h0BAD_0001);
    checkOutput("jump_pc_d", pc_d, 32'h0100_0040);

    applyStimulus(2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'd2, 32'h0100_0200, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'd0, 32'h0, 1'b0, 1'b1, 32'h1111_1111);
    checkOutput("branch_pc_f", pc_f, 32'h0100_0200);
    checkOutput("branch_discard", 32'(valid_d), 32'h0);

    applyStimulus(2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    saved_pc = pc_f;
    applyStimulus(2'd0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    checkOutput("hold_pc_f", pc_f, saved_pc + 32'd4);
    checkOutput("hold_req", 32'(imem_req), 32'h0);
    applyStimulus(2'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("hold_insn", insn_d, 32'hDEAD_BEEF);
    checkOutput("hold_pc_d", pc_d, saved_pc);

    applyStimulus(2'd1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    applyStimulus(2'd0, 32'h0, 1'b0, 1'b1, 32'h0000_0AAA);
    checkOutput("wrap_pc_f", pc_f, 32'h0);

`ifndef FETCH_MISALIGN_TRAP_EN
    applyStimulus(2'd1, 32'h0100_0042, 1'b0, 1'b0, 32'h0);
    checkOutput("align_pc_f", pc_f, 32'h0100_0040);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      r = int'($urandom_range(0, 99));
      r_sel = (r < 8) ? 2'd1 : (r < 14) ? 2'd2 : (r < 18) ? 2'd3 : 2'd0;
      r_ret = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_ret = r_ret & 32'hFFFF_FFFC;
`endif
      applyStimulus(r_sel, r_ret, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6), $urandom);
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    doReset();
    applyStimulus(2'd1, 32'h0100_0042, 1'b0, 1'b0, 32'h0);
    checkOutput("trap_flag", 32'(misalign_trap), 32'h1);
    checkOutput("trap_bad_addr", bad_addr, 32'h0100_0042);
    checkOutput("trap_pc_f", pc_f, 32'h0100_0000);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'd0, 32'h0, 1'b0, 1'b1, 32'h0);
      checkOutput("trap_req", 32'(imem_req), 32'h0);
    end
    doReset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
